// File: rtl/tank_barrel_array_if.sv
// tank_barrel_array_if: packed per-tank motion inputs and barrel/fire outputs
interface tank_barrel_array_if #(
  parameter int NUM_TANKS = 2,
  parameter int COORD_W = 10
);
  logic [NUM_TANKS*COORD_W-1:0] TankX;
  logic [NUM_TANKS*COORD_W-1:0] TankY;
  logic [NUM_TANKS*COORD_W-1:0] Tank_Size;
  logic [2*NUM_TANKS-1:0] p_direction;
  logic [NUM_TANKS-1:0] fire;
  logic [NUM_TANKS*COORD_W-1:0] BarrelX;
  logic [NUM_TANKS*COORD_W-1:0] BarrelY;
  logic [NUM_TANKS*COORD_W-1:0] Barrel_Length_Halved;
  logic [NUM_TANKS*COORD_W-1:0] Barrel_Height_Halved;
  logic [NUM_TANKS-1:0] fire_ready;
  logic [NUM_TANKS-1:0] shot_launch;
  modport master (
    output TankX, TankY, Tank_Size, p_direction, fire,
    input BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, fire_ready, shot_launch
  );
  modport slave (
    input TankX, TankY, Tank_Size, p_direction, fire,
    output BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, fire_ready, shot_launch
  );
endinterface

// File: rtl/tank_barrel_array.sv
// tank_barrel_array: per-tank barrel geometry with fire-recoil FSM, cooldown and shot pulse
module tank_barrel_array #(
  parameter int NUM_TANKS = 2,
  parameter int COORD_W = 10,
  parameter int LONG_DIM = 6,
  parameter int SHORT_DIM = 4,
  parameter int GAP = 3,
  parameter int RECOIL_DEPTH = 3,
  parameter int RECOIL_HOLD = 2
) (
  input logic frame_clk,
  input logic Reset,
  tank_barrel_array_if.slave bus
);
  typedef enum logic [1:0] {READY, HOLD, RETURN} state_t;
  localparam logic [COORD_W-1:0] ONE = 1;
  localparam logic [COORD_W-1:0] GAP_W = COORD_W'(GAP);
  localparam logic [COORD_W-1:0] DEPTH_W = COORD_W'(RECOIL_DEPTH);
  localparam logic [COORD_W-1:0] HOLD_W = COORD_W'(RECOIL_HOLD);
  localparam logic [COORD_W-1:0] LONG_W = COORD_W'(LONG_DIM);
  localparam logic [COORD_W-1:0] SHORT_W = COORD_W'(SHORT_DIM);
  state_t st [NUM_TANKS];
  state_t st_n [NUM_TANKS];
  logic [COORD_W-1:0] rc [NUM_TANKS];
  logic [COORD_W-1:0] rc_n [NUM_TANKS];
  logic [COORD_W-1:0] hc [NUM_TANKS];
  logic [COORD_W-1:0] hc_n [NUM_TANKS];
  logic [COORD_W-1:0] off [NUM_TANKS];
  logic [COORD_W-1:0] x_n [NUM_TANKS];
  logic [COORD_W-1:0] y_n [NUM_TANKS];
  logic [COORD_W-1:0] tx [NUM_TANKS];
  logic [COORD_W-1:0] ty [NUM_TANKS];
  logic [1:0] dir [NUM_TANKS];
  logic [NUM_TANKS-1:0] acc;
  always_comb begin
    acc = '0;
    for (int t = 0; t < NUM_TANKS; t++) begin
      st_n[t] = st[t];
      rc_n[t] = rc[t];
      hc_n[t] = hc[t];
      case (st[t])
        READY: if (bus.fire[t]) begin
          st_n[t] = HOLD;
          rc_n[t] = DEPTH_W;
          hc_n[t] = HOLD_W - ONE;
          acc[t] = 1'b1;
        end
        HOLD: if (hc[t] != '0) hc_n[t] = hc[t] - ONE;
          else begin
            st_n[t] = RETURN;
            rc_n[t] = DEPTH_W - ONE;
          end
        default: begin
          rc_n[t] = rc[t] - ONE;
          if (rc[t] == ONE) st_n[t] = READY;
        end
      endcase
      // geometry uses the post-edge recoil so retraction lines up with shot_launch
      tx[t] = bus.TankX[t*COORD_W +: COORD_W];
      ty[t] = bus.TankY[t*COORD_W +: COORD_W];
      dir[t] = bus.p_direction[2*t +: 2];
      off[t] = bus.Tank_Size[t*COORD_W +: COORD_W] + GAP_W - rc_n[t];
      x_n[t] = dir[t] == 2'b00 ? tx[t] - off[t] : dir[t] == 2'b01 ? tx[t] + off[t] : tx[t];
      y_n[t] = dir[t] == 2'b10 ? ty[t] + off[t] : dir[t] == 2'b11 ? ty[t] - off[t] : ty[t];
    end
  end
  always_ff @(posedge frame_clk) begin
    for (int t = 0; t < NUM_TANKS; t++) begin
      if (Reset) begin
        st[t] <= READY;
        rc[t] <= '0;
        hc[t] <= '0;
        bus.BarrelX[t*COORD_W +: COORD_W] <= '0;
        bus.BarrelY[t*COORD_W +: COORD_W] <= '0;
        bus.Barrel_Length_Halved[t*COORD_W +: COORD_W] <= '0;
        bus.Barrel_Height_Halved[t*COORD_W +: COORD_W] <= '0;
        bus.fire_ready[t] <= 1'b1;
        bus.shot_launch[t] <= 1'b0;
      end else begin
        st[t] <= st_n[t];
        rc[t] <= rc_n[t];
        hc[t] <= hc_n[t];
        bus.BarrelX[t*COORD_W +: COORD_W] <= x_n[t];
        bus.BarrelY[t*COORD_W +: COORD_W] <= y_n[t];
        bus.Barrel_Length_Halved[t*COORD_W +: COORD_W] <= dir[t][1] ? LONG_W : SHORT_W;
        bus.Barrel_Height_Halved[t*COORD_W +: COORD_W] <= dir[t][1] ? SHORT_W : LONG_W;
        bus.fire_ready[t] <= st_n[t] == READY;
        bus.shot_launch[t] <= acc[t];
      end
    end
  end
endmodule

// File: tb/tb_tank_barrel_array.sv
// tb_tank_barrel_array: scoreboard bench comparing DUT against a frame-phase reference model
module tb_tank_barrel_array;
  localparam int W = 10;
  localparam int BUSY = 4;
  typedef struct {
    logic [2*W-1:0] x, y, lh, hh;
    logic [1:0] fr, sl;
  } exp_t;
  logic clk, rst;
  int n_cmp, n_bad;
  int phase [2];
  exp_t sb [$];
  tank_barrel_array_if #(.NUM_TANKS(2), .COORD_W(W)) bus ();
  tank_barrel_array dut (.frame_clk(clk), .Reset(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set_tank(input int t, input int x, input int y, input int s, input logic [1:0] d);
    bus.TankX[t*W +: W] = W'(x);
    bus.TankY[t*W +: W] = W'(y);
    bus.Tank_Size[t*W +: W] = W'(s);
    bus.p_direction[2*t +: 2] = d;
  endtask
  task automatic step(input logic r, input logic [1:0] f);
    exp_t e;
    logic [W-1:0] rcv, o, tx, ty;
    logic [1:0] d;
    rst = r;
    bus.fire = f;
    e.x = '0; e.y = '0; e.lh = '0; e.hh = '0; e.fr = 2'b11; e.sl = 2'b00;
    for (int t = 0; t < 2; t++) begin
      if (r) phase[t] = 0;
      else if (phase[t] == 0 && f[t]) begin
        phase[t] = 1;
        e.sl[t] = 1'b1;
      end else if (phase[t] != 0) phase[t] = phase[t] == BUSY ? 0 : phase[t] + 1;
      if (!r) begin
        rcv = phase[t] == 0 ? W'(0) : phase[t] <= 2 ? W'(3) : W'(3 - (phase[t] - 2));
        o = bus.Tank_Size[t*W +: W] + W'(3) - rcv;
        tx = bus.TankX[t*W +: W];
        ty = bus.TankY[t*W +: W];
        d = bus.p_direction[2*t +: 2];
        case (d)
          2'b00: begin e.x[t*W +: W] = tx - o; e.y[t*W +: W] = ty; end
          2'b01: begin e.x[t*W +: W] = tx + o; e.y[t*W +: W] = ty; end
          2'b10: begin e.x[t*W +: W] = tx; e.y[t*W +: W] = ty + o; end
          default: begin e.x[t*W +: W] = tx; e.y[t*W +: W] = ty - o; end
        endcase
        e.lh[t*W +: W] = d[1] ? W'(6) : W'(4);
        e.hh[t*W +: W] = d[1] ? W'(4) : W'(6);
        e.fr[t] = phase[t] == 0;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("x%0d", t), 32'(bus.BarrelX[t*W +: W]), 32'(e.x[t*W +: W]));
      chk($sformatf("y%0d", t), 32'(bus.BarrelY[t*W +: W]), 32'(e.y[t*W +: W]));
      chk($sformatf("len%0d", t), 32'(bus.Barrel_Length_Halved[t*W +: W]), 32'(e.lh[t*W +: W]));
      chk($sformatf("hgt%0d", t), 32'(bus.Barrel_Height_Halved[t*W +: W]), 32'(e.hh[t*W +: W]));
    end
    chk("fire_ready", 32'(bus.fire_ready), 32'(e.fr));
    chk("shot_launch", 32'(bus.shot_launch), 32'(e.sl));
  endtask
  initial begin
    int shots;
    n_cmp = 0; n_bad = 0;
    phase[0] = 0; phase[1] = 0;
    rst = 1'b1;
    bus.fire = 2'b00;
    set_tank(0, 100, 200, 8, 2'b01);
    set_tank(1, 50, 5, 8, 2'b11);
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    chk("rst_ready", 32'(bus.fire_ready), 32'd3);
    chk("rst_shot", 32'(bus.shot_launch), 32'd0);
    chk("rst_x0", 32'(bus.BarrelX[0 +: W]), 32'd0);
    chk("rst_len1", 32'(bus.Barrel_Length_Halved[W +: W]), 32'd0);
    step(1'b0, 2'b00);
    chk("wrap_y1", 32'(bus.BarrelY[W +: W]), 32'd1018);
    chk("len1_up", 32'(bus.Barrel_Length_Halved[W +: W]), 32'd6);
    chk("hgt1_up", 32'(bus.Barrel_Height_Halved[W +: W]), 32'd4);
    chk("idle_x0", 32'(bus.BarrelX[0 +: W]), 32'd111);
    step(1'b0, 2'b01);
    chk("e0_x0", 32'(bus.BarrelX[0 +: W]), 32'd108);
    chk("e0_shot", 32'(bus.shot_launch), 32'd1);
    step(1'b0, 2'b00);
    chk("e1_x0", 32'(bus.BarrelX[0 +: W]), 32'd108);
    chk("e1_shot", 32'(bus.shot_launch), 32'd0);
    step(1'b0, 2'b00);
    chk("e2_x0", 32'(bus.BarrelX[0 +: W]), 32'd109);
    step(1'b0, 2'b00);
    chk("e3_x0", 32'(bus.BarrelX[0 +: W]), 32'd110);
    chk("e3_ready", 32'(bus.fire_ready), 32'd2);
    step(1'b0, 2'b00);
    chk("e4_x0", 32'(bus.BarrelX[0 +: W]), 32'd111);
    chk("e4_ready", 32'(bus.fire_ready), 32'd3);
    chk("e4_len0", 32'(bus.Barrel_Length_Halved[0 +: W]), 32'd4);
    shots = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 2'b01);
      shots += int'(bus.shot_launch[0]);
    end
    chk("hold_shots", 32'(shots), 32'd3);
    step(1'b0, 2'b11);
    chk("both_shot", 32'(bus.shot_launch), 32'd3);
    set_tank(0, 100, 200, 8, 2'b10);
    step(1'b0, 2'b00);
    chk("turn_y0", 32'(bus.BarrelY[0 +: W]), 32'd208);
    chk("turn_x0", 32'(bus.BarrelX[0 +: W]), 32'd100);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00);
    chk("both_ready", 32'(bus.fire_ready), 32'd3);
    set_tank(0, 100, 200, 8, 2'b01);
    step(1'b0, 2'b01);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    chk("ret_x0", 32'(bus.BarrelX[0 +: W]), 32'd109);
    step(1'b1, 2'b01);
    chk("mid_rst_ready", 32'(bus.fire_ready), 32'd3);
    chk("mid_rst_shot", 32'(bus.shot_launch), 32'd0);
    step(1'b0, 2'b01);
    chk("post_rst_shot", 32'(bus.shot_launch), 32'd1);
    chk("post_rst_x0", 32'(bus.BarrelX[0 +: W]), 32'd108);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) set_tank(0, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 40), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) set_tank(1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 40), 2'($urandom_range(0, 3)));
      step($urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tank_barrel_array.md
Name: tank_barrel_array

Overview:
- Drives barrel geometry and recoil animation for NUM_TANKS independent tanks.
- Generalises the single-tank barrel-attachment block with a per-tank fire-recoil state machine, a fire-ready cooldown and a shot-launch pulse.
- Sits between the tank motion/control logic and the colour mapper.
- Also feeds the projectile spawner, which consumes the shot pulse and barrel position.

Parameters:
NUM_TANKS, 2, number of independent tank channels
COORD_W, 10, width of every coordinate and size field
LONG_DIM, 6, barrel half-extent along the firing axis
SHORT_DIM, 4, barrel half-extent across the firing axis
GAP, 3, nominal distance from tank edge to barrel centre
RECOIL_DEPTH, 3, pixels the barrel retracts on firing; legal range 2 to GAP+min tank size
RECOIL_HOLD, 2, frames held at full recoil; must be at least 1

Ports:
frame_clk  in  1  frame clock; all state updates on its rising edge
Reset  in  1  synchronous, active-high reset
TankX  in  NUM_TANKS*COORD_W  packed tank centre X; tank i at bits [i*COORD_W +: COORD_W]
TankY  in  NUM_TANKS*COORD_W  packed tank centre Y
Tank_Size  in  NUM_TANKS*COORD_W  packed tank half-size
p_direction  in  2*NUM_TANKS  packed facing: 00 left, 01 right, 10 down, 11 up
fire  in  NUM_TANKS  per-tank fire request, sampled each edge
BarrelX  out  NUM_TANKS*COORD_W  packed barrel centre X
BarrelY  out  NUM_TANKS*COORD_W  packed barrel centre Y
Barrel_Length_Halved  out  NUM_TANKS*COORD_W  packed X half-extent
Barrel_Height_Halved  out  NUM_TANKS*COORD_W  packed Y half-extent
fire_ready  out  NUM_TANKS  high when the tank can accept fire
shot_launch  out  NUM_TANKS  one-frame pulse on each accepted fire

Behaviour:
- Clock, reset and priority
  - One clock: frame_clk.
  - Reset is synchronous and active-high and has priority over all other inputs.
  - Reset values:
    - all tanks in READY
    - recoil = 0, hold_cnt = 0
    - BarrelX/Y and both half-extents = 0
    - fire_ready = all ones
    - shot_launch = 0
- Channels
  - Tanks are fully independent.
  - Simultaneous fire on several tanks is accepted on all of them in the same edge.
- Per-tank FSM (recoil register 0..RECOIL_DEPTH)
  - READY: on fire=1, go to HOLD; recoil <= RECOIL_DEPTH; hold_cnt <= RECOIL_HOLD-1; shot_launch <= 1.
  - HOLD: if hold_cnt != 0, decrement hold_cnt. If hold_cnt == 0, go to RETURN and set recoil <= RECOIL_DEPTH-1.
  - RETURN: recoil <= recoil-1. If recoil == 1, go to READY (recoil becomes 0).
  - fire outside READY is ignored; it is not queued.
  - shot_launch is 0 on every edge that does not accept a fire.
- fire_ready is registered and equals (next state == READY).
  - Busy window after an accepted fire: RECOIL_HOLD + RECOIL_DEPTH - 1 frames (4 with defaults).
  - Earliest re-fire is accepted on the edge after fire_ready returns high.
- Geometry (registered every edge from current inputs and the NEXT recoil value, so retraction appears in the same frame as shot_launch)
  - off = Size + GAP - recoil_next.
  - 00: X = TankX - off, Y = TankY; Length = SHORT_DIM, Height = LONG_DIM.
  - 01: X = TankX + off, Y = TankY; Length = SHORT_DIM, Height = LONG_DIM.
  - 10: X = TankX, Y = TankY + off; Length = LONG_DIM, Height = SHORT_DIM.
  - 11: X = TankX, Y = TankY - off; Length = LONG_DIM, Height = SHORT_DIM.
- Arithmetic is modulo 2^COORD_W; no clamping or saturation (off-screen wrap is the consumer's concern).
- Direction change mid-recoil: geometry follows the new direction immediately and the recoil sequence continues unchanged.
- Reset mid-recoil: state is abandoned and the tank is READY after the reset edge; no shot_launch is emitted.

Test Plan:
1. Reset asserted over 2 edges with fire=11 -> after release: fire_ready=11, shot_launch=00, all geometry outputs 0.
2. Tank0 at (100,200), Size 8, dir 01, pulse fire0 at edge e0 -> recoil visible same frame as shot_launch:
   - after e0 and e1: BarrelX=108, shot_launch0=1 after e0 only
   - after e2: 109; after e3: 110
   - after e4: 111, fire_ready0=1
   - Barrel_Length_Halved=4, Height=6 throughout
3. Hold fire0=1 continuously, defaults -> shot_launch0 pulses exactly every 5 frames; fire_ready0 is low for 4 frames after each pulse.
4. Tank1 dir 11 at (50,5), Size 8, no fire -> BarrelY = 5-11 = 1018 (wrap); Length=6, Height=4; tank0 outputs unaffected.
5. Fire both tanks same edge; switch tank0 to dir 10 during HOLD -> both shot_launch bits set together; tank0 BarrelY = TankY + Size + GAP - 3 while recoil continues; tank0 returns to READY on the same edge as tank1.
6. Assert Reset during tank0 RETURN (recoil=2) -> next frame: recoil offset gone, fire_ready0=1; a fire on the following edge is accepted normally.
